// File: rtl/sun_pll_fbdiv_if.sv
// Ratio-update handshake bundle for the PLL feedback divider.
//
// Valid/ready semantics (4-phase level handshake): the master raises
// DIV_REQ with DIV_N stable; the slave samples DIV_N once on acceptance,
// raises DIV_ACK when the new ratio is active, and keeps it high until the
// master drops DIV_REQ. The slave then drops DIV_ACK, and only after that
// may the master raise DIV_REQ again.
//
// Signals:
//   DIV_N   [W-1:0] requested divide ratio        (master -> slave)
//   DIV_REQ         ratio-update request level    (master -> slave)
//   DIV_ACK         ratio-update acknowledge      (slave  -> master)
interface sun_pll_fbdiv_if #(
  parameter int W = 8
);
  logic [W-1:0] DIV_N;
  logic         DIV_REQ;
  logic         DIV_ACK;

  modport master (output DIV_N, output DIV_REQ, input DIV_ACK);
  modport slave  (input DIV_N, input DIV_REQ, output DIV_ACK);
endinterface

// File: rtl/sun_pll_fbdiv.sv
// Programmable feedback divider for the PLL. It divides the level-shifted
// oscillator clock CK by the active ratio n_act and produces the feedback
// clock CK_FB (high for floor(n_act/2) cycles of every period) plus a
// one-cycle terminal-count pulse TC, which coincides with the rising edge
// of CK_FB. The ratio is changed through a 4-phase request/acknowledge
// handshake, and a new ratio takes effect only at a period boundary, so
// CK_FB never glitches.
//
// Ports:
//   CK        input         divider clock, rising edge
//   RST       input         synchronous active-high reset
//   EN        input         divider enable (0 = idle, outputs low)
//   div_if    slave modport DIV_N / DIV_REQ in, DIV_ACK out (registered)
//   CK_FB     output        divided clock (registered)
//   TC        output        terminal-count pulse (registered)
//   DIV_ACT   output [W]    currently active divide ratio
//   DBG_STATE output [2]    handshake FSM state (0 IDLE, 1 PEND, 2 ACK)
module sun_pll_fbdiv #(
  parameter int W    = 8,
  parameter int NMIN = 2,
  parameter int NRST = 16
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          EN,
  sun_pll_fbdiv_if.slave div_if,
  output logic          CK_FB,
  output logic          TC,
  output logic [W-1:0]  DIV_ACT,
  output logic [1:0]    DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2
  } hs_state_e;

  hs_state_e    state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] n_act_q;
  logic [W-1:0] pend_q;
  logic         ck_fb_q;
  logic         tc_q;
  logic         ack_q;

  logic [W-1:0] cnt_d;
  logic [W-1:0] half_n;
  logic [W-1:0] req_n_clamped;
  logic         wrap_d;

  // n_act is never below NMIN (>= 2), so n_act-1 cannot underflow.
  always_comb begin
    wrap_d        = (cnt_q == n_act_q - W'(1));
    cnt_d         = wrap_d ? '0 : cnt_q + W'(1);
    half_n        = n_act_q >> 1;
    req_n_clamped = (div_if.DIV_N < W'(NMIN)) ? W'(NMIN) : div_if.DIV_N;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_act_q <= W'(NRST);
      pend_q  <= '0;
      ck_fb_q <= 1'b0;
      tc_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      // Counting always uses the ratio active before this edge; a ratio
      // applied on this edge governs counting from the next edge onward.
      if (EN) begin
        cnt_q   <= cnt_d;
        ck_fb_q <= (cnt_d < half_n);
        tc_q    <= (cnt_d == '0);
      end else begin
        cnt_q   <= '0;
        ck_fb_q <= 1'b0;
        tc_q    <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (div_if.DIV_REQ) begin
            pend_q  <= req_n_clamped;
            state_q <= S_PEND;
          end
        end
        S_PEND: begin
          // With the divider idle there is no period to protect, so the
          // ratio can be applied immediately.
          if (!EN || (cnt_d == '0)) begin
            n_act_q <= pend_q;
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          if (!div_if.DIV_REQ) begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CK_FB          = ck_fb_q;
  assign TC             = tc_q;
  assign DIV_ACT        = n_act_q;
  assign div_if.DIV_ACK = ack_q;
  assign DBG_STATE      = state_q;

endmodule

// File: tb/tb_sun_pll_fbdiv.sv
module tb_sun_pll_fbdiv;
  localparam int W    = 8;
  localparam int NMIN = 2;
  localparam int NRST = 16;

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  logic RST;
  logic EN;
  always #5 CK = ~CK;

  sun_pll_fbdiv_if #(.W(W)) bus ();
  logic         CK_FB;
  logic         TC;
  logic [W-1:0] DIV_ACT;
  logic [1:0]   DBG_STATE;

  sun_pll_fbdiv #(.W(W), .NMIN(NMIN), .NRST(NRST)) dut (
    .CK        (CK),
    .RST       (RST),
    .EN        (EN),
    .div_if    (bus),
    .CK_FB     (CK_FB),
    .TC        (TC),
    .DIV_ACT   (DIV_ACT),
    .DBG_STATE (DBG_STATE)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // The model tracks the position inside the current period (0 = period
  // start) and derives outputs from it; the handshake is described as
  // "an update is waiting" and "acknowledge is showing".
  int m_pos;
  int m_n;
  int m_pend_val;
  bit m_pending;
  bit m_ack;
  bit m_fb;
  bit m_tc;
  bit cmp_en = 1'b0;

  always @(posedge CK) begin
    int next_pos;
    int rq;
    if (RST) begin
      m_pos = 0; m_n = NRST; m_fb = 0; m_tc = 0;
      m_ack = 0; m_pending = 0; m_pend_val = 0;
      cmp_en = 1'b1;
    end else begin
      next_pos = EN ? (m_pos + 1) % m_n : 0;
      m_fb = EN && (next_pos < m_n / 2);
      m_tc = EN && (next_pos == 0);
      if (m_pending) begin
        if (!EN || next_pos == 0) begin
          m_n = m_pend_val;
          m_pending = 0;
          m_ack = 1;
        end
      end else if (m_ack) begin
        if (!bus.DIV_REQ) m_ack = 0;
      end else if (bus.DIV_REQ) begin
        rq = int'(bus.DIV_N);
        m_pend_val = (rq < NMIN) ? NMIN : rq;
        m_pending = 1;
      end
      m_pos = next_pos;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge CK) begin
    if (cmp_en) begin
      checks++;
      if (CK_FB !== m_fb || TC !== m_tc || bus.DIV_ACK !== m_ack ||
          DIV_ACT !== W'(m_n)) begin
        errors++;
        $display("FAIL model t=%0t CK_FB=%0b/%0b TC=%0b/%0b ACK=%0b/%0b DIV_ACT=%0d/%0d (got/exp)",
                 $time, CK_FB, m_fb, TC, m_tc, bus.DIV_ACK, m_ack, DIV_ACT, m_n);
      end
    end
  end

  // ---------------- driver / helper tasks ----------------
  task automatic step();
    @(negedge CK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns at a negedge where TC is high (DUT is at period start).
  task automatic wait_tc(input string name);
    int n = 0;
    step();
    while (TC !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    if (TC !== 1'b1) chk({name, "_tc_timeout"}, 0, 1);
  endtask

  // Measures one full period starting at the next TC; ends on the TC that
  // starts the following period.
  task automatic measure(input string name, input int exp_per, input int exp_high);
    int per;
    int high;
    wait_tc(name);
    per = 1;
    high = int'(CK_FB);
    step();
    while (TC !== 1'b1 && per < 600) begin
      per++;
      high += int'(CK_FB);
      step();
    end
    chk({name, "_period"}, per, exp_per);
    chk({name, "_high"}, high, exp_high);
  endtask

  task automatic do_req(input string name, input int n, input int exp_act);
    int k = 0;
    bus.DIV_N = W'(n);
    bus.DIV_REQ = 1'b1;
    step();
    while (bus.DIV_ACK !== 1'b1 && k < 600) begin
      step();
      k++;
    end
    chk({name, "_ack_seen"}, int'(bus.DIV_ACK === 1'b1), 1);
    chk({name, "_div_act"}, int'(DIV_ACT), exp_act);
    bus.DIV_REQ = 1'b0;
    step();
    chk({name, "_ack_low"}, int'(bus.DIV_ACK), 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int k;
    RST = 1'b1; EN = 1'b0; bus.DIV_REQ = 1'b0; bus.DIV_N = '0;
    step(); step();
    chk("rst_div_act", int'(DIV_ACT), 16);
    chk("rst_ck_fb", int'(CK_FB), 0);
    chk("rst_tc", int'(TC), 0);
    chk("rst_ack", int'(bus.DIV_ACK), 0);

    // Default ratio; first enabled edge gives CK_FB=1 with no TC.
    RST = 1'b0; EN = 1'b1;
    step();
    chk("first_en_fb", int'(CK_FB), 1);
    chk("first_en_tc", int'(TC), 0);
    measure("default", 16, 8);

    // Handshake timing: request at cnt=3 with ratio 16.
    step(); step(); step();
    bus.DIV_N = 8'd4; bus.DIV_REQ = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("hs_hold_act", int'(DIV_ACT), 16);
      chk("hs_hold_ack", int'(bus.DIV_ACK), 0);
    end
    step();
    chk("hs_ack_on_wrap", int'(bus.DIV_ACK), 1);
    chk("hs_tc_on_wrap", int'(TC), 1);
    chk("hs_new_act", int'(DIV_ACT), 4);
    measure("ratio4", 4, 2);
    bus.DIV_REQ = 1'b0;
    chk("hs_ack_before_drop", int'(bus.DIV_ACK), 1);
    step();
    chk("hs_ack_fall", int'(bus.DIV_ACK), 0);

    // Odd ratio and minimum ratio.
    do_req("req5", 5, 5);
    measure("ratio5", 5, 2);
    do_req("req2", 2, 2);
    measure("ratio2", 2, 1);

    // Clamp of illegal small ratios.
    do_req("req0", 0, 2);
    measure("clamp0", 2, 1);
    do_req("req1", 1, 2);
    measure("clamp1", 2, 1);

    // Request accepted on the wrap edge; DIV_N changes while pending.
    do_req("req6", 6, 6);
    wait_tc("wrapreq");
    for (int i = 0; i < 5; i++) step();
    bus.DIV_N = 8'd8; bus.DIV_REQ = 1'b1;
    step();
    chk("wrapreq_tc", int'(TC), 1);
    chk("wrapreq_act_old", int'(DIV_ACT), 6);
    bus.DIV_N = 8'd3;
    k = 0;
    step(); k++;
    while (bus.DIV_ACK !== 1'b1 && k < 50) begin
      step(); k++;
    end
    chk("wrapreq_edges", k, 6);
    chk("wrapreq_act_new", int'(DIV_ACT), 8);
    bus.DIV_REQ = 1'b0;
    step();
    measure("ratio8", 8, 4);

    // EN dropped while pending: applies on the next edge.
    bus.DIV_N = 8'd10; bus.DIV_REQ = 1'b1;
    step();
    EN = 1'b0;
    step();
    chk("endis_ack", int'(bus.DIV_ACK), 1);
    chk("endis_fb", int'(CK_FB), 0);
    chk("endis_act", int'(DIV_ACT), 10);
    EN = 1'b1;
    step();
    chk("reen_fb", int'(CK_FB), 1);
    chk("reen_tc", int'(TC), 0);
    bus.DIV_REQ = 1'b0;
    step();
    chk("endis_ack_fall", int'(bus.DIV_ACK), 0);
    measure("ratio10", 10, 5);

    // Reset while pending discards the pending ratio.
    bus.DIV_N = 8'd3; bus.DIV_REQ = 1'b1;
    step();
    RST = 1'b1; bus.DIV_REQ = 1'b0;
    step();
    chk("rstpend_act", int'(DIV_ACT), 16);
    chk("rstpend_ack", int'(bus.DIV_ACK), 0);
    RST = 1'b0;
    measure("after_rst", 16, 8);
    chk("rstpend_act_later", int'(DIV_ACT), 16);

    // DIV_REQ dropped while pending still completes the update.
    bus.DIV_N = 8'd6; bus.DIV_REQ = 1'b1;
    step();
    bus.DIV_REQ = 1'b0;
    k = 0;
    step(); k++;
    while (bus.DIV_ACK !== 1'b1 && k < 50) begin
      step(); k++;
    end
    chk("dropreq_edges", k, 15);
    chk("dropreq_act", int'(DIV_ACT), 6);
    step();
    chk("dropreq_ack_pulse", int'(bus.DIV_ACK), 0);
    measure("ratio6b", 6, 3);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
